// File: rtl/random_arb.sv
// Round-robin arbiter that hands out words from a 71-bit LFSR, each word
// only after the generator has taken MIN_STEPS fresh steps since the last one.
module random_arb #(
  parameter int NREQ      = 4,
  parameter int WORD_W    = 32,
  parameter int MIN_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [70:0]       seed_data,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  output logic [70:0]       state_q
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

  state_e            state;
  logic [70:0]       g_q, g_d;
  logic [6:0]        fresh_q, fresh_d;
  logic              en_q;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]   winner;
  logic [PW-1:0]     winIdx;
  logic [PW-1:0]     idx;
  logic              found;
  logic              step;
  logic              grant;
  logic              feedback;

  // The mode is decoded from the registered enable and the freshness count.
  always_comb begin
    state = IDLE;
    if (en_q) begin
      state = (fresh_q == 7'(MIN_STEPS)) ? READY : FILL;
    end
  end

  // Search starts one past the last winner and wraps around.
  always_comb begin
    winner = '0;
    winIdx = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        winIdx      = idx;
        found       = 1'b1;
      end
    end
  end

  assign step     = en && !seed_load;
  assign grant    = (state == READY) && (|req) && !seed_load;
  assign feedback = ~(g_q[70] ^ g_q[64]) ^ (&g_q[69:0]);

  // A seed load overrides everything; a grant resets freshness even though
  // the generator itself may still step on that edge.
  always_comb begin
    g_d      = g_q;
    fresh_d  = fresh_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (seed_load) begin
      g_d     = seed_data;
      fresh_d = '0;
    end else begin
      if (step) begin
        g_d = {g_q[69:0], feedback};
        if (fresh_q != 7'(MIN_STEPS)) begin
          fresh_d = fresh_q + 7'd1;
        end
      end
      if (grant) begin
        fresh_d  = '0;
        gnt_d    = winner;
        rvalid_d = 1'b1;
        rdata_d  = g_q[WORD_W-1:0];
        ptr_d    = winIdx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q      <= '0;
      fresh_q  <= '0;
      en_q     <= 1'b0;
      ptr_q    <= PW'(NREQ - 1);
      gnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      g_q      <= g_d;
      fresh_q  <= fresh_d;
      en_q     <= en;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign state_q = g_q;

endmodule

// File: tb/tb_random_arb.sv
// Bench for random_arb: a cycle-level reference model checked on every
// falling edge, plus directed scenarios with literal expectations.
module tb_random_arb;

  localparam int NREQ      = 4;
  localparam int WORD_W    = 32;
  localparam int MIN_STEPS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              seed_load;
  logic [70:0]       seed_data;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [WORD_W-1:0] rdata;
  logic              rvalid;
  logic [70:0]       state_q;

  random_arb #(.NREQ(NREQ), .WORD_W(WORD_W), .MIN_STEPS(MIN_STEPS)) dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_data(seed_data),
    .req(req), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .state_q(state_q)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [70:0]       mG;
  int                mFresh;
  bit                mEnq;
  int                mPtr;
  logic [NREQ-1:0]   mGnt;
  bit                mRvalid;
  logic [WORD_W-1:0] mRdata;

  int  passCount  = 0;
  int  totalCount = 0;
  bit  checkOn    = 1'b0;

  task automatic checkOutput(input string name, input logic [70:0] actual,
                             input logic [70:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic logic [70:0] nextG(input logic [70:0] v);
    return {v[69:0], ~(v[70] ^ v[64]) ^ (&v[69:0])};
  endfunction

  task automatic resetModel();
    mG = '0; mFresh = 0; mEnq = 0; mPtr = NREQ - 1;
    mGnt = '0; mRvalid = 0; mRdata = '0;
  endtask

  // Drive inputs, advance one rising edge, update the model alongside.
  task automatic applyStimulus(input bit enV, input bit seedV,
                               input logic [70:0] dataV, input logic [NREQ-1:0] reqV);
    bit              grantNow;
    bit              stepNow;
    logic [70:0]     nG;
    int              nFresh;
    int              nPtr;
    logic [NREQ-1:0] nGnt;
    en = enV; seed_load = seedV; seed_data = dataV; req = reqV;
    grantNow = mEnq && (mFresh == MIN_STEPS) && (reqV != 0) && !seedV;
    stepNow  = enV && !seedV;
    nG     = seedV ? dataV : (stepNow ? nextG(mG) : mG);
    nFresh = seedV ? 0 : (grantNow ? 0 : (stepNow ? ((mFresh + 1 > MIN_STEPS) ? MIN_STEPS : mFresh + 1) : mFresh));
    nPtr   = mPtr;
    nGnt   = '0;
    if (grantNow) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (nGnt == 0 && reqV[(mPtr + k) % NREQ]) begin
          nGnt[(mPtr + k) % NREQ] = 1'b1;
          nPtr = (mPtr + k) % NREQ;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      resetModel();
    end else begin
      if (grantNow) mRdata = mG[WORD_W-1:0];
      mG = nG; mFresh = nFresh; mEnq = enV; mPtr = nPtr;
      mGnt = nGnt; mRvalid = grantNow;
    end
    #1;
  endtask

  // Run with fixed inputs until a grant appears; -1 when the budget expires.
  task automatic waitGrant(input bit enV, input logic [NREQ-1:0] reqV, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(enV, 1'b0, '0, reqV);
      if (rvalid) begin
        cycles = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model gnt", 71'(gnt), 71'(mGnt));
      checkOutput("model rvalid", 71'(rvalid), 71'(mRvalid));
      checkOutput("model rdata", 71'(rdata), 71'(mRdata));
      checkOutput("model state_q", state_q, mG);
    end
  end

  initial begin
    int          cycles;
    logic [70:0] frozen;
    logic [70:0] pattern;
    pattern = 71'h2A_5555_AAAA_1234_5678;

    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_data = '0; req = '0;
    resetModel();
    checkOn = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    rst = 1'b0;
    checkOutput("reset gnt", 71'(gnt), 71'd0);
    checkOutput("reset rvalid", 71'(rvalid), 71'd0);
    checkOutput("reset rdata", 71'(rdata), 71'd0);
    checkOutput("reset state_q", state_q, 71'd0);

    // Fill from zero: 32 steps shift in ones
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, '0, 4'b0000);
    checkOutput("fill state_q", state_q, 71'h0_0000_0000_FFFF_FFFF);
    checkOutput("fill rvalid", 71'(rvalid), 71'd0);

    applyStimulus(1'b1, 1'b0, '0, 4'b0101);
    checkOutput("first gnt", 71'(gnt), 71'(4'b0001));
    checkOutput("first rdata", 71'(rdata), 71'(32'hFFFF_FFFF));
    checkOutput("first rvalid", 71'(rvalid), 71'd1);
    waitGrant(1'b1, 4'b0100, cycles);
    checkOutput("second grant spacing", 71'(cycles), 71'd33);
    checkOutput("second gnt", 71'(gnt), 71'(4'b0100));

    // Seed with all ones then one step
    applyStimulus(1'b1, 1'b1, {71{1'b1}}, 4'b0000);
    checkOutput("seed load state_q", state_q, {71{1'b1}});
    applyStimulus(1'b1, 1'b0, '0, 4'b0000);
    checkOutput("seed step state_q", state_q, 71'h7F_FFFF_FFFF_FFFF_FFFE);

    // Reach READY, then collide a seed load with a request
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b0, '0, 4'b0000);
    applyStimulus(1'b1, 1'b1, pattern, 4'b0001);
    checkOutput("collision rvalid", 71'(rvalid), 71'd0);
    checkOutput("collision gnt", 71'(gnt), 71'd0);
    checkOutput("collision state_q", state_q, pattern);

    // Freeze at fresh=10 for 20 cycles
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0, 4'b0000);
    frozen = mG;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0, 4'b1111);
    checkOutput("idle frozen state_q", state_q, frozen);
    waitGrant(1'b1, 4'b1111, cycles);
    checkOutput("resume grant latency", 71'(cycles), 71'd23);
    checkOutput("resume gnt pointer kept", 71'(gnt), 71'(4'b1000));

    // Asynchronous reset in the middle of FILL
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    #2;
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("async rst gnt", 71'(gnt), 71'd0);
    checkOutput("async rst rvalid", 71'(rvalid), 71'd0);
    checkOutput("async rst rdata", 71'(rdata), 71'd0);
    checkOutput("async rst state_q", state_q, 71'd0);
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    rst = 1'b0;
    waitGrant(1'b1, 4'b1111, cycles);
    checkOutput("post reset grant latency", 71'(cycles), 71'd33);
    checkOutput("post reset gnt", 71'(gnt), 71'(4'b0001));

    applyStimulus(1'b1, 1'b0, '0, 4'b0000);
    checkOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
